// File: rtl/imem_access_arbiter.sv
// Arbitrates the instruction memory between the program loader and the fetch stage.
// The loader owns memory until load_done; afterwards fetch has priority with a streak limit.
module imem_access_arbiter #(
   parameter int                    ADDRWIDTH        = 32,
   parameter int                    DATAWIDTH        = 32,
   parameter logic [ADDRWIDTH-1:0]  START_ADDR       = 32'h01000000,
   parameter int                    MAX_FETCH_STREAK = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 f_req,
   input  logic [ADDRWIDTH-1:0] f_addr,
   output logic                 f_gnt,
   output logic                 f_rvalid,
   output logic [DATAWIDTH-1:0] f_rdata,
   output logic                 f_err,
   input  logic                 l_req,
   input  logic                 l_we,
   input  logic [ADDRWIDTH-1:0] l_addr,
   input  logic [DATAWIDTH-1:0] l_wdata,
   output logic                 l_gnt,
   output logic                 l_rvalid,
   output logic [DATAWIDTH-1:0] l_rdata,
   output logic                 l_err,
   input  logic                 load_done,
   output logic                 run,
   output logic [ADDRWIDTH-1:0] mem_address,
   output logic                 mem_read_write,
   output logic [DATAWIDTH-1:0] mem_data_in,
   input  logic [DATAWIDTH-1:0] mem_data_out
);

   // state   | meaning
   // ST_LOAD | loader-only access while the program image is written
   // ST_RUN  | core running; fetch preferred, loader forced through after a full streak
   typedef enum logic {ST_LOAD, ST_RUN} state_t;

   localparam logic [3:0] STREAK_MAX = 4'(MAX_FETCH_STREAK);

   state_t               state_q, state_d;
   logic [3:0]           streak_q, streak_d;
   logic                 f_rvalid_q, l_rvalid_q;
   logic                 f_mis, l_mis;

   assign f_mis = |f_addr[1:0];
   assign l_mis = |l_addr[1:0];

   always_comb begin
      state_d = state_q;
      f_gnt   = 1'b0;
      l_gnt   = 1'b0;
      if (!reset) begin
         case (state_q)
            ST_LOAD: begin
               l_gnt = l_req;
               if (load_done) state_d = ST_RUN;
            end
            ST_RUN: begin
               if (f_req && l_req) begin
                  if (streak_q == STREAK_MAX) l_gnt = 1'b1;
                  else                        f_gnt = 1'b1;
               end else begin
                  f_gnt = f_req;
                  l_gnt = l_req;
               end
            end
            default: state_d = ST_LOAD;
         endcase
      end
   end

   // Only consecutive contended fetch grants count; anything else restarts the streak.
   always_comb begin
      streak_d = 4'd0;
      if (state_q == ST_RUN && l_req && f_gnt)
         streak_d = (streak_q >= STREAK_MAX) ? STREAK_MAX : streak_q + 4'd1;
   end

   always_comb begin
      mem_address    = START_ADDR;
      mem_read_write = 1'b0;
      mem_data_in    = '0;
      if (f_gnt && !f_mis) begin
         mem_address = f_addr;
      end else if (l_gnt && !l_mis) begin
         mem_address = l_addr;
         if (l_we) begin
            mem_read_write = 1'b1;
            mem_data_in    = l_wdata;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_LOAD;
         streak_q   <= 4'd0;
         f_rvalid_q <= 1'b0;
         l_rvalid_q <= 1'b0;
         f_rdata    <= '0;
         l_rdata    <= '0;
         f_err      <= 1'b0;
         l_err      <= 1'b0;
      end else begin
         state_q    <= state_d;
         streak_q   <= streak_d;
         f_rvalid_q <= f_gnt;
         l_rvalid_q <= l_gnt;
         if (f_gnt) begin
            f_err   <= f_mis;
            f_rdata <= f_mis ? '0 : mem_data_out;
         end
         if (l_gnt) begin
            l_err   <= l_mis;
            l_rdata <= (l_mis || l_we) ? '0 : mem_data_out;
         end
      end
   end

   // A response launched just before reset must not appear during the reset cycle.
   assign f_rvalid = f_rvalid_q && !reset;
   assign l_rvalid = l_rvalid_q && !reset;
   assign run      = (state_q == ST_RUN);

endmodule

// File: doc/imem_access_arbiter.md
Name: imem_access_arbiter

Overview:
- Sits between the core's fetch stage, the program loader and the single-port, byte-addressed instruction memory (address / read_write / data_in / data_out, combinational read, posedge write).
- After reset, the loader owns the memory and writes the program image starting at START_ADDR. It then releases the core via `run`.
- In run mode, fetch has priority. A streak limiter guarantees the loader (debug/patch path) cannot be starved.

Parameters:
ADDRWIDTH, 32, address width of all address ports
DATAWIDTH, 32, instruction/data word width
START_ADDR, 32'h01000000, idle value driven on mem_address; first program address
MAX_FETCH_STREAK, 4, consecutive contended fetch grants before the loader is forced through (1..15)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
f_req  in  1  fetch read request
f_addr  in  ADDRWIDTH  fetch byte address
f_gnt  out  1  fetch request accepted this cycle
f_rvalid  out  1  fetch response valid (one cycle after f_gnt)
f_rdata  out  DATAWIDTH  fetch read data
f_err  out  1  fetch response is a misalignment error
l_req  in  1  loader request
l_we  in  1  loader write (1) / read (0)
l_addr  in  ADDRWIDTH  loader byte address
l_wdata  in  DATAWIDTH  loader write data
l_gnt  out  1  loader request accepted this cycle
l_rvalid  out  1  loader response valid (reads and writes)
l_rdata  out  DATAWIDTH  loader read data (0 for writes)
l_err  out  1  loader misalignment error
load_done  in  1  loader finished image; pulse
run  out  1  core enable; high in RUN state
mem_address  out  ADDRWIDTH  to memory address
mem_read_write  out  1  to memory; 1 = write
mem_data_in  out  DATAWIDTH  to memory write data
mem_data_out  in  DATAWIDTH  from memory read data

Behaviour:
- States:
  - LOAD (reset state): only the loader is granted; f_gnt = 0.
  - RUN: both requesters are eligible.
  - LOAD -> RUN on the clock edge where load_done = 1. The grant decision in that cycle still uses LOAD rules. RUN is terminal until reset. load_done in RUN is ignored.
- run = 1 iff state == RUN (registered).
- Grant:
  - Combinational from the current state and requests; at most one of f_gnt/l_gnt is high.
  - RUN, both requesting: fetch wins unless streak == MAX_FETCH_STREAK, in which case the loader wins.
  - Single requester: that requester wins.
- streak (4-bit):
  - +1 on a fetch grant with l_req = 1, saturating at MAX_FETCH_STREAK.
  - Cleared on any loader grant, and on any cycle with l_req = 0.
  - Held at 0 in LOAD.
- Memory drive (combinational, in the grant cycle):
  - The granted requester's address goes to mem_address.
  - mem_read_write = 1 only for an aligned loader write; mem_data_in = l_wdata on that write.
  - No grant, or misaligned grant: mem_address = START_ADDR, mem_read_write = 0, mem_data_in = 0.
- Alignment: addr[1:0] != 0 is misaligned. The request is still granted (consumed) but no memory access occurs. The response carries err = 1 and rdata = 0.
- Response (registered, latency 1):
  - The posedge after a grant raises the matching *_rvalid for exactly one cycle.
  - For reads, mem_data_out sampled in the grant cycle goes to *_rdata. Writes return rdata = 0.
  - Back-to-back grants produce back-to-back rvalid pulses.
  - rdata/err hold their last value when rvalid = 0.
- Requesters hold req/addr/data stable until gnt. The arbiter does not buffer a request that was not granted.
- Reset values: f_gnt = l_gnt = 0 (no grant during reset), f_rvalid = l_rvalid = 0, f_rdata = l_rdata = 0, f_err = l_err = 0, run = 0, state = LOAD, streak = 0, mem_read_write = 0, mem_address = START_ADDR.
- Reset mid-operation: a response pending from a grant in the cycle before reset is dropped (no rvalid). Any write in a reset cycle is suppressed.

Test Plan:
- Boot load: reset; loader writes 0x00000013 to 0x01000000 and 0x00100093 to 0x01000004; pulse load_done -> during LOAD, f_req = 1 gets f_gnt = 0; run rises the cycle after load_done; a fetch of 0x01000004 returns f_rvalid = 1, f_rdata = 0x00100093 one cycle after f_gnt.
- Priority/starvation in RUN with MAX_FETCH_STREAK = 4: f_req and l_req held high continuously -> grant pattern F,F,F,F,L,F,F,F,F,L; every grant is followed next cycle by the correct rvalid.
- Misalignment: in RUN, f_addr = 0x01000002 -> f_gnt = 1, mem_read_write = 0, mem_address = START_ADDR; next cycle f_rvalid = 1, f_err = 1, f_rdata = 0. Loader write to 0x01000001 -> memory unchanged, l_err = 1.
- Edge-coincident load_done: l_req write and load_done in the same LOAD cycle with f_req = 1 -> loader granted and the write is performed; fetch is first granted in the following cycle.
- Mid-operation reset: fetch granted at cycle N, reset = 1 at cycle N+1 -> f_rvalid stays 0; run = 0, state = LOAD, mem_address = START_ADDR after reset.
- Loader readback in RUN: l_we = 0 at 0x01000000 with f_req = 0 -> l_rvalid next cycle, l_rdata = 0x00000013, l_err = 0.
